jtag_reg_bank: RTL and testbench



---
 rtl/jtag_pkg.sv | 34 +++
 rtl/jtag_shift_reg.sv | 47 ++++
 rtl/jtag_reg_bank.sv | 162 ++++++++++++++++
 tb/tb_jtag_reg_bank.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - TAP state codes, opcodes and IR capture pattern for the JTAG register bank
package jtag_pkg;

    localparam logic [3:0] TAP_TLR    = 4'd0;
    localparam logic [3:0] TAP_RTI    = 4'd1;
    localparam logic [3:0] TAP_SEL_DR = 4'd2;
    localparam logic [3:0] TAP_CAP_DR = 4'd3;
    localparam logic [3:0] TAP_SH_DR  = 4'd4;
    localparam logic [3:0] TAP_EX1_DR = 4'd5;
    localparam logic [3:0] TAP_PAU_DR = 4'd6;
    localparam logic [3:0] TAP_EX2_DR = 4'd7;
    localparam logic [3:0] TAP_UPD_DR = 4'd8;
    localparam logic [3:0] TAP_SEL_IR = 4'd9;
    localparam logic [3:0] TAP_CAP_IR = 4'd10;
    localparam logic [3:0] TAP_SH_IR  = 4'd11;
    localparam logic [3:0] TAP_EX1_IR = 4'd12;
    localparam logic [3:0] TAP_PAU_IR = 4'd13;
    localparam logic [3:0] TAP_EX2_IR = 4'd14;
    localparam logic [3:0] TAP_UPD_IR = 4'd15;

    localparam logic [3:0] OP_IDCODE = 4'b0001;
    localparam logic [3:0] OP_USER   = 4'b0010;
    localparam logic [3:0] OP_BYPASS = 4'b1111;

    // Zero-extended to IR_W when loaded into the IR shift register.
    localparam logic [1:0] IR_CAPTURE = 2'b01;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// rtl/jtag_shift_reg.sv - capture/shift/hold cell shifting right with sin entering the MSB
module jtag_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cap_en,
    input  logic         shift_en,
    input  logic [W-1:0] cap_val,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         sout
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] shifted;

    generate
        if (W == 1) begin : g_one
            assign shifted = sin;
        end else begin : g_multi
            assign shifted = {sin, q_q[W-1:1]};
        end
    endgenerate

    always_comb begin
        q_d = q_q;
        if (cap_en) begin
            q_d = cap_val;
        end else if (shift_en) begin
            q_d = shifted;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign sout = q_q[0];

endmodule

// File: rtl/jtag_reg_bank.sv
// rtl/jtag_reg_bank.sv - JTAG instruction register and IDCODE/BYPASS/USER data register bank
module jtag_reg_bank
    import jtag_pkg::*;
#(
    parameter int          IR_W       = 4,
    parameter int          DR_W       = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            clk,
    input  logic            TRST_n,
    input  logic [3:0]      tap_state,
    input  logic            TDI,
    output logic            TDO,
    output logic            tdo_en,
    output logic [IR_W-1:0] ir_out,
    input  logic [DR_W-1:0] user_dr_in,
    output logic [DR_W-1:0] user_dr_out,
    output logic            user_update
);

    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_d;
    logic [DR_W-1:0] usr_upd_q;
    logic [DR_W-1:0] usr_upd_d;
    logic            user_update_q;
    logic            user_update_d;

    dr_sel_e         dr_sel;
    logic            ir_cap_en;
    logic            ir_shift_en;
    logic            id_cap_en;
    logic            id_shift_en;
    logic            byp_cap_en;
    logic            byp_shift_en;
    logic            usr_cap_en;
    logic            usr_shift_en;
    logic            usr_fire;

    logic [IR_W-1:0] ir_shift_q;
    logic            ir_sout;
    logic [31:0]     id_q_unused;
    logic            id_sout;
    logic [0:0]      byp_q_unused;
    logic            byp_sout;
    logic [DR_W-1:0] usr_shift_q;
    logic            usr_sout;

    // The DR selection only follows ir_q, which is stable for a whole DR scan.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == IR_W'(OP_IDCODE)) begin
            dr_sel = DR_IDCODE;
        end else if (ir_q == IR_W'(OP_USER)) begin
            dr_sel = DR_USER;
        end
    end

    always_comb begin
        ir_cap_en    = (tap_state == TAP_CAP_IR);
        ir_shift_en  = (tap_state == TAP_SH_IR);
        id_cap_en    = (tap_state == TAP_CAP_DR) && (dr_sel == DR_IDCODE);
        id_shift_en  = (tap_state == TAP_SH_DR)  && (dr_sel == DR_IDCODE);
        byp_cap_en   = (tap_state == TAP_CAP_DR) && (dr_sel == DR_BYPASS);
        byp_shift_en = (tap_state == TAP_SH_DR)  && (dr_sel == DR_BYPASS);
        usr_cap_en   = (tap_state == TAP_CAP_DR) && (dr_sel == DR_USER);
        usr_shift_en = (tap_state == TAP_SH_DR)  && (dr_sel == DR_USER);
        usr_fire     = (tap_state == TAP_UPD_DR) && (dr_sel == DR_USER);
    end

    always_comb begin
        ir_d = ir_q;
        if (tap_state == TAP_TLR) begin
            ir_d = IR_W'(OP_IDCODE);
        end else if (tap_state == TAP_UPD_IR) begin
            ir_d = ir_shift_q;
        end
    end

    always_comb begin
        usr_upd_d     = usr_upd_q;
        user_update_d = 1'b0;
        if (usr_fire) begin
            usr_upd_d     = usr_shift_q;
            user_update_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_q          <= IR_W'(OP_IDCODE);
            usr_upd_q     <= '0;
            user_update_q <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            usr_upd_q     <= usr_upd_d;
            user_update_q <= user_update_d;
        end
    end

    jtag_shift_reg #(.W(IR_W)) u_ir_shift (
        .clk      (clk),
        .rst_n    (TRST_n),
        .cap_en   (ir_cap_en),
        .shift_en (ir_shift_en),
        .cap_val  (IR_W'(IR_CAPTURE)),
        .sin      (TDI),
        .q        (ir_shift_q),
        .sout     (ir_sout)
    );

    jtag_shift_reg #(.W(32)) u_id_shift (
        .clk      (clk),
        .rst_n    (TRST_n),
        .cap_en   (id_cap_en),
        .shift_en (id_shift_en),
        .cap_val  (IDCODE_VAL),
        .sin      (TDI),
        .q        (id_q_unused),
        .sout     (id_sout)
    );

    jtag_shift_reg #(.W(1)) u_byp_shift (
        .clk      (clk),
        .rst_n    (TRST_n),
        .cap_en   (byp_cap_en),
        .shift_en (byp_shift_en),
        .cap_val  (1'b0),
        .sin      (TDI),
        .q        (byp_q_unused),
        .sout     (byp_sout)
    );

    jtag_shift_reg #(.W(DR_W)) u_usr_shift (
        .clk      (clk),
        .rst_n    (TRST_n),
        .cap_en   (usr_cap_en),
        .shift_en (usr_shift_en),
        .cap_val  (user_dr_in),
        .sin      (TDI),
        .q        (usr_shift_q),
        .sout     (usr_sout)
    );

    always_comb begin
        TDO = 1'b0;
        if (tap_state == TAP_SH_IR) begin
            TDO = ir_sout;
        end else if (tap_state == TAP_SH_DR) begin
            case (dr_sel)
                DR_IDCODE: TDO = id_sout;
                DR_USER:   TDO = usr_sout;
                default:   TDO = byp_sout;
            endcase
        end
    end

    assign tdo_en      = (tap_state == TAP_SH_DR) || (tap_state == TAP_SH_IR);
    assign ir_out      = ir_q;
    assign user_dr_out = usr_upd_q;
    assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_reg_bank.sv
// tb/tb_jtag_reg_bank.sv - self-checking bench for jtag_reg_bank
module tb_jtag_reg_bank;
    import jtag_pkg::*;

    localparam logic [31:0] IDV = 32'h1000_0001;

    logic       clk;
    logic       TRST_n;
    logic [3:0] tap_state;
    logic       TDI;
    logic       TDO;
    logic       tdo_en;
    logic [3:0] ir_out;
    logic [7:0] user_dr_in;
    logic [7:0] user_dr_out;
    logic       user_update;

    jtag_reg_bank #(.IR_W(4), .DR_W(8), .IDCODE_VAL(IDV)) dut (
        .clk         (clk),
        .TRST_n      (TRST_n),
        .tap_state   (tap_state),
        .TDI         (TDI),
        .TDO         (TDO),
        .tdo_en      (tdo_en),
        .ir_out      (ir_out),
        .user_dr_in  (user_dr_in),
        .user_dr_out (user_dr_out),
        .user_update (user_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       tdi;
        logic       chk;
        logic       exp_tdo;
        logic       ir_chk;
        logic [3:0] exp_ir;
    } vec_t;

    vec_t tbl[$];
    bit   exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   upd_cnt = 0;
    int   u0;

    always @(negedge clk) if (user_update === 1'b1) upd_cnt++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive one TAP cycle; TDO is combinational so it is checked before the rising edge.
    task automatic step(input logic [3:0] st, input logic tdi);
        bit e;
        @(negedge clk);
        tap_state = st;
        TDI = tdi;
        #1;
        check("tdo_en", tdo_en, (st == TAP_SH_DR || st == TAP_SH_IR));
        if (st == TAP_SH_DR || st == TAP_SH_IR) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard: got empty queue want expected bit");
            end else begin
                e = exp_q.pop_front();
                check("tdo", TDO, e);
            end
        end else begin
            check("tdo_idle", TDO, 1'b0);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
    endtask

    task automatic load_ir(input logic [3:0] op);
        step(TAP_SEL_DR, 1'b0);
        step(TAP_SEL_IR, 1'b0);
        step(TAP_CAP_IR, 1'b0);
        push_bits(32'h1, 4);
        for (int k = 0; k < 4; k++) step(TAP_SH_IR, op[k]);
        step(TAP_EX1_IR, 1'b0);
        step(TAP_UPD_IR, 1'b0);
        step(TAP_RTI, 1'b0);
        check("ir_load", ir_out, op);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] c3;
        logic [3:0] bp;
        a5 = 8'hA5;
        c3 = 8'hC3;
        bp = 4'b1011;
        TRST_n = 1'b0;
        tap_state = TAP_TLR;
        TDI = 1'b0;
        user_dr_in = 8'h00;

        repeat (2) @(negedge clk);
        #1;
        check("rst_ir", ir_out, OP_IDCODE);
        check("rst_udo", user_dr_out, 8'h00);
        check("rst_upd", user_update, 1'b0);
        check("rst_tdo", TDO, 1'b0);
        @(negedge clk);
        TRST_n = 1'b1;

        // IDCODE read out straight after reset
        step(TAP_RTI, 1'b0);
        check("idc_ir", ir_out, OP_IDCODE);
        step(TAP_SEL_DR, 1'b0);
        step(TAP_CAP_DR, 1'b0);
        push_bits(IDV, 32);
        for (int i = 0; i < 32; i++) step(TAP_SH_DR, 1'b0);
        step(TAP_EX1_DR, 1'b0);
        step(TAP_UPD_DR, 1'b0);
        step(TAP_RTI, 1'b0);
        check("idc_noupd", upd_cnt, 0);

        // IR = 1111 then an 8-bit BYPASS scan, table driven
        tbl.push_back('{TAP_SEL_DR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_SEL_IR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_CAP_IR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_SH_IR,  1'b1, 1'b1, 1'b1, 1'b0, 4'h0});
        tbl.push_back('{TAP_SH_IR,  1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_SH_IR,  1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_SH_IR,  1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_EX1_IR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_UPD_IR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_SEL_DR, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF});
        tbl.push_back('{TAP_CAP_DR, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF});
        for (int k = 0; k < 8; k++)
            tbl.push_back('{TAP_SH_DR, a5[k], 1'b1, (k == 0) ? 1'b0 : a5[(k == 0) ? 0 : k - 1], 1'b0, 4'h0});
        tbl.push_back('{TAP_EX1_DR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_UPD_DR, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});
        tbl.push_back('{TAP_RTI,    1'b0, 1'b0, 1'b0, 1'b1, 4'hF});
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].chk) exp_q.push_back(tbl[i].exp_tdo);
            step(tbl[i].st, tbl[i].tdi);
            if (tbl[i].ir_chk) check("tbl_ir", ir_out, tbl[i].exp_ir);
        end
        check("byp_noupd", upd_cnt, 0);

        // USER capture/shift/update, UpdDR followed directly by SelDR
        load_ir(OP_USER);
        user_dr_in = 8'h3C;
        step(TAP_SEL_DR, 1'b0);
        step(TAP_CAP_DR, 1'b0);
        push_bits(32'h3C, 8);
        for (int k = 0; k < 8; k++) step(TAP_SH_DR, a5[k]);
        step(TAP_EX1_DR, 1'b0);
        u0 = upd_cnt;
        check("usr_pre_upd", user_update, 1'b0);
        step(TAP_UPD_DR, 1'b0);
        step(TAP_SEL_DR, 1'b0);
        check("usr_upd_hi", user_update, 1'b1);
        check("usr_dout", user_dr_out, 8'hA5);
        step(TAP_SEL_IR, 1'b0);
        check("usr_upd_lo", user_update, 1'b0);
        load_ir(OP_USER);
        check("usr_one_pulse", upd_cnt - u0, 1);

        // USER scan split by a pause
        user_dr_in = 8'h5A;
        u0 = upd_cnt;
        step(TAP_SEL_DR, 1'b0);
        step(TAP_CAP_DR, 1'b0);
        push_bits(32'h5A, 8);
        for (int k = 0; k < 4; k++) step(TAP_SH_DR, c3[k]);
        step(TAP_EX1_DR, 1'b1);
        repeat (3) step(TAP_PAU_DR, 1'b1);
        step(TAP_EX2_DR, 1'b1);
        for (int k = 4; k < 8; k++) step(TAP_SH_DR, c3[k]);
        step(TAP_EX1_DR, 1'b0);
        step(TAP_UPD_DR, 1'b0);
        step(TAP_RTI, 1'b0);
        check("pau_dout", user_dr_out, 8'hC3);
        check("pau_pulse", upd_cnt - u0, 1);

        // Reset in the middle of a USER shift
        user_dr_in = 8'h96;
        u0 = upd_cnt;
        step(TAP_SEL_DR, 1'b0);
        step(TAP_CAP_DR, 1'b0);
        push_bits(32'h96, 5);
        for (int k = 0; k < 5; k++) step(TAP_SH_DR, 1'b1);
        TRST_n = 1'b0;
        #1;
        check("trst_ir", ir_out, OP_IDCODE);
        check("trst_dout", user_dr_out, 8'h00);
        check("trst_upd", user_update, 1'b0);
        check("trst_tdo", TDO, 1'b0);
        step(TAP_EX1_DR, 1'b0);
        step(TAP_UPD_DR, 1'b0);
        @(negedge clk);
        TRST_n = 1'b1;
        step(TAP_RTI, 1'b0);
        check("trst_nopulse", upd_cnt - u0, 0);
        check("trst_dout2", user_dr_out, 8'h00);
        check("trst_ir2", ir_out, OP_IDCODE);

        // Undefined opcode decodes as BYPASS, then TLR restores IDCODE
        load_ir(4'b0101);
        step(TAP_SEL_DR, 1'b0);
        step(TAP_CAP_DR, 1'b0);
        exp_q.push_back(1'b0);
        push_bits({29'd0, bp[2:0]}, 3);
        for (int k = 0; k < 4; k++) step(TAP_SH_DR, bp[k]);
        step(TAP_EX1_DR, 1'b0);
        step(TAP_UPD_DR, 1'b0);
        step(TAP_SEL_DR, 1'b0);
        check("undef_ir", ir_out, 4'b0101);
        check("undef_dout", user_dr_out, 8'h00);
        step(TAP_SEL_IR, 1'b0);
        step(TAP_TLR, 1'b0);
        step(TAP_RTI, 1'b0);
        check("tlr_ir", ir_out, OP_IDCODE);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
